// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller driving an external
// right-shift SFR that holds the multiplier; accumulates SIZE partial products.
module shift_add_mult_ctrl #(
   parameter int SIZE = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SIZE-1:0]   multiplicand,
   input  logic [SIZE-1:0]   multiplier,
   input  logic              sfr_lsb,
   output logic              sfr_ld,
   output logic              sfr_right,
   output logic [SIZE-1:0]   sfr_d,
   output logic [2*SIZE-1:0] product,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [2*SIZE-1:0] mcand;
   logic [2*SIZE-1:0] acc;
   logic [CNT_W-1:0]  cnt;

   // The SFR loads on the same edge that accepts start, so its load enable
   // must follow start combinationally while idle.
   assign sfr_ld    = (state == IDLE) && start;
   assign sfr_right = (state == CALC);
   assign sfr_d     = multiplier;
   assign product   = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= {{SIZE{1'b0}}, multiplicand};
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               if (sfr_lsb) begin
                  acc <= acc + mcand;
               end
               mcand <= mcand << 1;
               if (cnt == LAST_ITER) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: SIZE=8 instance under directed and
// random traffic, plus a SIZE=32 instance for full-width products.
module tb_shift_add_mult_ctrl;

   localparam int S = 8;
   localparam int W = 32;

   typedef struct packed {
      logic [63:0] p;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst32_n = 1'b0;

   always #5 clk = ~clk;

   // ---------------- SIZE=8 instance ----------------
   logic           start = 1'b0;
   logic [S-1:0]   a = '0;
   logic [S-1:0]   b = '0;
   logic           sfr_lsb;
   logic           sfr_ld;
   logic           sfr_right;
   logic [S-1:0]   sfr_d;
   logic [2*S-1:0] product;
   logic           busy;
   logic           done;
   logic [S-1:0]   sfr;

   shift_add_mult_ctrl #(.SIZE(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(a), .multiplier(b),
      .sfr_lsb(sfr_lsb), .sfr_ld(sfr_ld), .sfr_right(sfr_right), .sfr_d(sfr_d),
      .product(product), .busy(busy), .done(done)
   );

   // Environment: the right-shift SFR holding the multiplier.
   always @(posedge clk) begin
      if (sfr_ld) sfr <= sfr_d;
      else if (sfr_right) sfr <= sfr >> 1;
   end
   assign sfr_lsb = sfr[0];

   // ---------------- SIZE=32 instance ----------------
   logic           start32 = 1'b0;
   logic [W-1:0]   a32 = '0;
   logic [W-1:0]   b32 = '0;
   logic           sfr_lsb32;
   logic           sfr_ld32;
   logic           sfr_right32;
   logic [W-1:0]   sfr_d32;
   logic [2*W-1:0] product32;
   logic           busy32;
   logic           done32;
   logic [W-1:0]   sfr32;

   shift_add_mult_ctrl #(.SIZE(W)) dut32 (
      .clk(clk), .rst_n(rst32_n), .start(start32), .multiplicand(a32), .multiplier(b32),
      .sfr_lsb(sfr_lsb32), .sfr_ld(sfr_ld32), .sfr_right(sfr_right32), .sfr_d(sfr_d32),
      .product(product32), .busy(busy32), .done(done32)
   );

   always @(posedge clk) begin
      if (sfr_ld32) sfr32 <= sfr_d32;
      else if (sfr_right32) sfr32 <= sfr32 >> 1;
   end
   assign sfr_lsb32 = sfr32[0];

   // ---------------- checking infrastructure ----------------
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: a busy countdown of SIZE+1 edges after each accepted
   // start; the product is simply A*B.
   int          rem = 0;
   logic [63:0] hold = '0;
   exp_t        q[$];
   exp_t        q32[$];
   exp_t        e;
   exp_t        e32;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem  = 0;
         hold = '0;
         q.delete();
      end else if (rem > 0) begin
         rem = rem - 1;
      end else if (start) begin
         hold = 64'(a) * 64'(b);
         q.push_back('{p: hold, c: cyc + 1});
         rem = S + 1;
      end
   end

   always @(posedge clk) begin
      if (rst32_n && start32)
         q32.push_back('{p: 64'(a32) * 64'(b32), c: cyc + 1});
   end

   // Monitor: per-cycle control decode plus scoreboard pop on done.
   always @(negedge clk) begin
      check("busy", 64'(busy), 64'(rem > 0));
      check("done", 64'(done), 64'(rem == 1));
      check("sfr_right", 64'(sfr_right), 64'(rem >= 2));
      check("sfr_ld", 64'(sfr_ld), 64'((rem == 0) && start));
      check("sfr_d", 64'(sfr_d), 64'(b));
      if (rem <= 1) check("product_hold", 64'(product), hold);
      if (rem == S + 1) check("acc_cleared", 64'(product), 64'd0);
      if (done === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            check("sb_product", 64'(product), e.p);
            check("sb_latency", 64'(cyc - e.c), 64'(S));
         end
      end
      if (done32 === 1'b1) begin
         checks++;
         if (q32.size() == 0) begin
            errors++;
            $display("FAIL sb32_unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
         end else begin
            e32 = q32.pop_front();
            check("sb32_product", product32, e32.p);
            check("sb32_latency", 64'(cyc - e32.c), 64'(W));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic st, input logic [S-1:0] aa, input logic [S-1:0] bb);
      @(posedge clk);
      #1;
      start = st;
      a = aa;
      b = bb;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, a, b);
   endtask

   task automatic pulse_reset(input int n);
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_product", 64'(product), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sfr_right", 64'(sfr_right), 64'd0);
      check("rst_sfr_ld", 64'(sfr_ld), 64'd0);
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rst32_n = 1'b1;
      idle(2);

      drv(1'b1, 8'd3, 8'd5);
      idle(14);
      drv(1'b1, 8'd255, 8'd255);
      idle(10);
      drv(1'b1, 8'hAB, 8'd0);
      idle(10);
      drv(1'b1, 8'd0, 8'hFF);
      idle(10);

      // Extra starts during CALC and DONE, then a held start.
      drv(1'b1, 8'd7, 8'd9);
      idle(3);
      drv(1'b1, 8'd7, 8'd9);
      idle(4);
      drv(1'b1, 8'd8, 8'd3);
      drv(1'b1, 8'd8, 8'd3);
      idle(12);

      // Reset mid-CALC, then a normal multiply.
      drv(1'b1, 8'd200, 8'd100);
      idle(4);
      pulse_reset(2);
      drv(1'b1, 8'd6, 8'd7);
      idle(30);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) pulse_reset(1);
         else drv($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
      end

      drv(1'b0, a, b);
      for (int i = 0; i < 80 && (q.size() != 0 || q32.size() != 0 || busy32 !== 1'b0); i++)
         @(posedge clk);
      @(negedge clk);
      check("sb_drain", 64'(q.size() + q32.size()), 64'd0);
      check("busy32_end", 64'(busy32), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      repeat (5) @(posedge clk);
      #1;
      start32 = 1'b1;
      a32 = 32'hFFFF_FFFF;
      b32 = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      start32 = 1'b1;
      a32 = $urandom;
      b32 = $urandom;
      @(posedge clk);
      #1;
      start32 = 1'b0;
   end

endmodule
